// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between a trace byte FIFO
// and a 4-byte host status frame; single-byte host commands set the config.
module uart_tx_scheduler #(
    parameter int FIFO_AW = 4,
    parameter int HOLDOFF = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trace_valid,
    input  logic [7:0]         trace_byte,
    input  logic               rx_strobe,
    input  logic [7:0]         rx_byte,
    input  logic               uart_busy,
    output logic               uart_transmit,
    output logic [7:0]         uart_byte,
    output logic [1:0]         width,
    output logic               trace_en,
    output logic               fifo_ovf,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic               src_st_q, src_st_d;
    logic [1:0]         fidx_q, fidx_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [7:0]         byte_q, byte_d;
    logic               pend_q, pend_d;
    logic [7:0]         snap1_q, snap1_d;
    logic [7:0]         snap2_q, snap2_d;
    logic [7:0]         snap3_q, snap3_d;
    logic [7:0]         drops_q, drops_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         width_q, width_d;
    logic               en_q, en_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [FIFO_AW-1:0] wr_q, wr_d;
    logic [FIFO_AW-1:0] rd_q, rd_d;
    logic [7:0]         mem [DEPTH];

    logic full;
    logic push_req;
    logic push;
    logic pop;
    logic drop;
    logic issue0;
    logic cmd_w;
    logic cmd_en;
    logic cmd_dis;
    logic cmd_clr;
    logic cmd_st;

    assign cmd_w   = rx_strobe && (rx_byte[7:2] == 6'b001100);
    assign cmd_en  = rx_strobe && (rx_byte == 8'h45);
    assign cmd_dis = rx_strobe && (rx_byte == 8'h44);
    assign cmd_clr = rx_strobe && (rx_byte == 8'h43);
    assign cmd_st  = rx_strobe && (rx_byte == 8'h53);

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign full     = (cnt_q == (FIFO_AW+1)'(DEPTH));
    assign pop      = (state_q == S_SEND) && !src_st_q;
    assign push_req = trace_valid && en_q;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign issue0   = (state_q == S_SEND) && src_st_q && (fidx_q == 2'd0);

    always_comb begin
        width_d = width_q;
        en_d    = en_q;
        unique case (1'b1)
            cmd_w:   width_d = rx_byte[1:0];
            cmd_en:  en_d = 1'b1;
            cmd_dis: en_d = 1'b0;
            default: ;
        endcase
    end

    always_comb begin
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (cmd_clr) begin
            ovf_d   = drop;
            drops_d = {7'd0, drop};
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != 8'hFF) begin
                drops_d = drops_q + 8'd1;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (cmd_st) begin
            pend_d = 1'b1;
        end
        if (issue0) begin
            pend_d = 1'b0;
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            wr_d = wr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + FIFO_AW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + (FIFO_AW+1)'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - (FIFO_AW+1)'(1);
        end
    end

    // Frame bytes 1-3 are frozen as byte 0 goes out
    always_comb begin
        snap1_d = snap1_q;
        snap2_d = snap2_q;
        snap3_d = snap3_q;
        if (issue0) begin
            snap1_d = {en_q, ovf_q, width_q, 4'h0};
            snap2_d = drops_q;
            snap3_d = 8'(cnt_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        src_st_d = src_st_q;
        fidx_d   = fidx_q;
        hcnt_d   = hcnt_q;
        byte_d   = byte_q;
        unique case (state_q)
            S_IDLE: begin
                if (!uart_busy) begin
                    if (pend_q) begin
                        state_d  = S_SEND;
                        src_st_d = 1'b1;
                        fidx_d   = 2'd0;
                        byte_d   = 8'hA5;
                    end else if (cnt_q != '0) begin
                        state_d  = S_SEND;
                        src_st_d = 1'b0;
                        byte_d   = mem[rd_q];
                    end
                end
            end
            S_SEND: begin
                state_d = S_HOLD;
                hcnt_d  = '0;
            end
            S_HOLD: begin
                if (hcnt_q == HW'(HOLDOFF - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_WAIT: begin
                if (!uart_busy) begin
                    if (src_st_q && (fidx_q != 2'd3)) begin
                        state_d = S_SEND;
                        fidx_d  = fidx_q + 2'd1;
                        unique case (fidx_q)
                            2'd0:    byte_d = snap1_q;
                            2'd1:    byte_d = snap2_q;
                            default: byte_d = snap3_q;
                        endcase
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src_st_q <= 1'b0;
            fidx_q   <= 2'd0;
            hcnt_q   <= '0;
            byte_q   <= 8'h00;
            pend_q   <= 1'b0;
            snap1_q  <= 8'h00;
            snap2_q  <= 8'h00;
            snap3_q  <= 8'h00;
            drops_q  <= 8'h00;
            ovf_q    <= 1'b0;
            width_q  <= 2'b11;
            en_q     <= 1'b1;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            src_st_q <= src_st_d;
            fidx_q   <= fidx_d;
            hcnt_q   <= hcnt_d;
            byte_q   <= byte_d;
            pend_q   <= pend_d;
            snap1_q  <= snap1_d;
            snap2_q  <= snap2_d;
            snap3_q  <= snap3_d;
            drops_q  <= drops_d;
            ovf_q    <= ovf_d;
            width_q  <= width_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= trace_byte;
        end
    end

    assign uart_transmit = (state_q == S_SEND);
    assign uart_byte     = byte_q;
    assign width         = width_q;
    assign trace_en      = en_q;
    assign fifo_ovf      = ovf_q;
    assign fifo_level    = cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed test-plan scenarios plus random traffic,
// checked every cycle against a timing-level behavioural model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int AW    = 4;
    localparam int HO    = 2;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          trace_valid;
    logic [7:0]    trace_byte;
    logic          rx_strobe;
    logic [7:0]    rx_byte;
    logic          uart_busy;
    logic          uart_transmit;
    logic [7:0]    uart_byte;
    logic [1:0]    width;
    logic          trace_en;
    logic          fifo_ovf;
    logic [AW:0]   fifo_level;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.FIFO_AW(AW), .HOLDOFF(HO)) dut (
        .clk(clk),
        .rst(rst),
        .trace_valid(trace_valid),
        .trace_byte(trace_byte),
        .rx_strobe(rx_strobe),
        .rx_byte(rx_byte),
        .uart_busy(uart_busy),
        .uart_transmit(uart_transmit),
        .uart_byte(uart_byte),
        .width(width),
        .trace_en(trace_en),
        .fifo_ovf(fifo_ovf),
        .fifo_level(fifo_level)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // reference model: FIFO as a queue, config as ints, issue times as cycle numbers
    logic [7:0] q[$];
    int m_width, m_en, m_ovf, m_drops, m_pend;
    int cyc;
    int m_issue_at, m_ibyte, m_wait_from, m_fidx;
    bit m_itrace;
    int snap[4];

    // UART stand-in and observed pulse log
    bit hold_busy, rand_busy, saw_pulse;
    int busy_cnt, busy_len;
    int obs_b[$];
    int obs_t[$];

    task automatic model_reset();
        q.delete();
        m_width = 3; m_en = 1; m_ovf = 0; m_drops = 0; m_pend = 0;
        m_issue_at = -1; m_ibyte = 0; m_wait_from = -1; m_fidx = -1;
        m_itrace = 0;
    endtask

    task automatic check_outputs();
        bit exp_tx;
        exp_tx = (m_issue_at == cyc);
        chk("uart_transmit", uart_transmit, exp_tx);
        if (exp_tx) chk("uart_byte", uart_byte, m_ibyte);
        chk("fifo_level", fifo_level, q.size());
        chk("width", width, m_width);
        chk("trace_en", trace_en, m_en);
        chk("fifo_ovf", fifo_ovf, m_ovf);
        if (uart_transmit) begin
            obs_b.push_back(uart_byte);
            obs_t.push_back(cyc);
            saw_pulse = 1;
        end
    endtask

    task automatic step(input bit tv, input int tb, input bit rs,
                        input int rb, input bit r);
        bit busy, pop, drop, issue0, clr;
        int sz;
        busy = hold_busy || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        if (saw_pulse) begin
            busy_cnt  = rand_busy ? int'($urandom_range(0, 12)) : busy_len;
            saw_pulse = 0;
        end
        rst = r;
        trace_valid = tv;
        trace_byte = tb[7:0];
        rx_strobe = rs;
        rx_byte = rb[7:0];
        uart_busy = busy;
        if (r) begin
            model_reset();
        end else begin
            sz = q.size();
            pop = (m_issue_at == cyc) && m_itrace;
            issue0 = (m_issue_at == cyc) && !m_itrace && (m_fidx == 0);
            drop = 0;
            if (m_issue_at == cyc) begin
                m_wait_from = cyc + 1 + HO;
                if (issue0) begin
                    snap[1] = m_en * 128 + m_ovf * 64 + m_width * 16;
                    snap[2] = m_drops;
                    snap[3] = sz;
                end
            end else if (m_wait_from >= 0) begin
                if (cyc >= m_wait_from && !busy) begin
                    m_wait_from = -1;
                    if (m_fidx >= 0 && m_fidx < 3) begin
                        m_fidx++;
                        m_issue_at = cyc + 1;
                        m_itrace = 0;
                        m_ibyte = snap[m_fidx];
                    end else begin
                        m_fidx = -1;
                    end
                end
            end else if (!busy) begin
                if (m_pend != 0) begin
                    m_issue_at = cyc + 1; m_itrace = 0;
                    m_ibyte = 'hA5; m_fidx = 0;
                end else if (sz > 0) begin
                    m_issue_at = cyc + 1; m_itrace = 1;
                    m_ibyte = q[0];
                end
            end
            if (tv && m_en != 0) begin
                if (sz < DEPTH || pop) q.push_back(tb[7:0]);
                else drop = 1;
            end
            if (pop) void'(q.pop_front());
            clr = rs && (rb[7:0] == 8'h43);
            if (clr) begin
                m_ovf = drop;
                m_drops = drop;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            if (rs) begin
                if (rb[7:0] >= 8'h30 && rb[7:0] <= 8'h33) m_width = rb[7:0] - 8'h30;
                if (rb[7:0] == 8'h45) m_en = 1;
                if (rb[7:0] == 8'h44) m_en = 0;
                if (rb[7:0] == 8'h53) m_pend = 1;
            end
            if (issue0) m_pend = 0;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic cmd(input int b);
        step(0, 0, 1, b, 0);
    endtask

    task automatic push(input int b);
        step(1, b, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 1);
        chk("rst_uart_byte", uart_byte, 0);
        chk("rst_uart_transmit", uart_transmit, 0);
        chk("rst_fifo_level", fifo_level, 0);
    endtask

    initial begin
        int t0, n, pick, rb;
        int exp3[8];
        rst = 1; trace_valid = 0; trace_byte = 0;
        rx_strobe = 0; rx_byte = 0; uart_busy = 0;
        model_reset();
        hold_busy = 0; rand_busy = 0; saw_pulse = 0;
        busy_cnt = 0; busy_len = 10; cyc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        chk("rst_width", width, 3);
        chk("rst_trace_en", trace_en, 1);
        chk("rst_uart_byte", uart_byte, 0);

        // three trace bytes, 10-cycle UART
        obs_b.delete(); obs_t.delete();
        t0 = cyc;
        push('h11); push('h22); push('h33);
        idle(60);
        chk("t1_npulses", obs_b.size(), 3);
        chk("t1_b0", obs_b[0], 'h11);
        chk("t1_b1", obs_b[1], 'h22);
        chk("t1_b2", obs_b[2], 'h33);
        chk("t1_latency", obs_t[0] - t0, 2);

        // overflow with UART stalled, then status frame
        do_reset();
        hold_busy = 1;
        for (int i = 0; i < DEPTH + 3; i++) push($urandom_range(0, 255));
        chk("ovf_flag", fifo_ovf, 1);
        chk("ovf_level", fifo_level, 16);
        cmd('h53);
        obs_b.delete();
        hold_busy = 0;
        idle(400);
        chk("ovf_npulses", obs_b.size(), 20);
        chk("ovf_st0", obs_b[0], 'hA5);
        chk("ovf_st1", obs_b[1], 'hF0);
        chk("ovf_st2", obs_b[2], 3);
        chk("ovf_st3", obs_b[3], 'h10);

        // status request mid-drain
        do_reset();
        obs_b.delete();
        push('hA1); push('hA2); push('hA3); push('hA4);
        cmd('h53);
        idle(200);
        exp3 = '{'hA1, 'hA5, 'hB0, 'h00, 'h03, 'hA2, 'hA3, 'hA4};
        chk("mid_npulses", obs_b.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("mid_b%0d", i), obs_b[i], exp3[i]);

        // width change, disable, discarded byte
        do_reset();
        cmd('h31);
        chk("w01", width, 1);
        cmd('h44);
        chk("en0", trace_en, 0);
        push('h77);
        chk("dis_level", fifo_level, 0);
        chk("dis_ovf", fifo_ovf, 0);
        cmd('h53);
        obs_b.delete();
        idle(80);
        chk("dis_npulses", obs_b.size(), 4);
        chk("dis_st1", obs_b[1], 'h10);
        chk("dis_st2", obs_b[2], 0);
        cmd('h45); cmd('h33);

        // drop and clear in the same cycle
        do_reset();
        hold_busy = 1;
        for (int i = 0; i < DEPTH + 2; i++) push(i);
        step(1, 'hEE, 1, 'h43, 0);
        chk("clr_ovf", fifo_ovf, 1);
        cmd('h53);
        obs_b.delete();
        hold_busy = 0;
        idle(80);
        chk("clr_st0", obs_b[0], 'hA5);
        chk("clr_st2", obs_b[2], 1);
        idle(300);

        // reset after status byte 1
        do_reset();
        hold_busy = 1;
        push('h5A); push('h5B); push('h5C);
        cmd('h53);
        obs_b.delete();
        hold_busy = 0;
        for (int k = 0; k < 200 && obs_b.size() < 2; k++) idle(1);
        chk("mr_reached", obs_b.size() >= 2, 1);
        chk("mr_b1", obs_b[1], 'hF0 & 'hB0);
        step(0, 0, 0, 0, 1);
        chk("mr_tx", uart_transmit, 0);
        chk("mr_byte", uart_byte, 0);
        chk("mr_level", fifo_level, 0);
        chk("mr_width", width, 3);
        chk("mr_en", trace_en, 1);
        chk("mr_ovf", fifo_ovf, 0);
        n = obs_b.size();
        idle(40);
        chk("mr_no_pulse", obs_b.size(), n);

        // random traffic
        rand_busy = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) hold_busy = !hold_busy;
            rb = 0;
            if ($urandom_range(0, 9) == 0) begin
                pick = $urandom_range(0, 9);
                case (pick)
                    0, 1, 2, 3: rb = 'h30 + pick;
                    4: rb = 'h43;
                    5: rb = 'h44;
                    6, 7: rb = 'h45;
                    8: rb = 'h53;
                    default: rb = $urandom_range(0, 255);
                endcase
            end
            step($urandom_range(0, 1), $urandom_range(0, 255), rb != 0, rb,
                 $urandom_range(0, 999) == 0);
        end
        hold_busy = 0;
        idle(400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
